// File: rtl/rv32_pkg.sv
// Shared RV32 types and constants for the writeback/register-file path.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;

  // Requester slots on the writeback arbiter
  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;

  // One-hot mask selecting a single architectural register
  function automatic logic [NREGS-1:0] reg_bit(input reg_idx_t idx);
    logic [NREGS-1:0] m;
    m      = {NREGS{1'b0}};
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at a rotating pointer and wraps.
// The pointer moves to one past the winner on every grant and holds otherwise.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [NREQ-1:0] gnt_s;
  int              best_s;
  int              dist_s;
  int              win_s;

  // Pick the valid requester closest to the pointer (distance measured modulo NREQ)
  always_comb begin
    gnt_s  = {NREQ{1'b0}};
    ptr_d  = ptr_q;
    best_s = NREQ;
    dist_s = 0;
    win_s  = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_i[i]) begin
        if (i >= int'(ptr_q)) begin
          dist_s = i - int'(ptr_q);
        end else begin
          dist_s = i + NREQ - int'(ptr_q);
        end
        if (dist_s < best_s) begin
          best_s = dist_s;
          win_s  = i;
        end else begin
          best_s = best_s;
        end
      end else begin
        dist_s = dist_s;
      end
    end
    // No grant while reset is asserted; otherwise grant the winner and rotate
    if (!rst_n) begin
      gnt_s = {NREQ{1'b0}};
      ptr_d = ptr_q;
    end else if (best_s < NREQ) begin
      for (int i = 0; i < NREQ; i++) begin
        gnt_s[i] = (i == win_s);
      end
      if (win_s + 1 >= NREQ) begin
        ptr_d = {PW{1'b0}};
      end else begin
        ptr_d = PW'(win_s + 1);
      end
    end else begin
      gnt_s = {NREQ{1'b0}};
      ptr_d = ptr_q;
    end
  end

  // Rotating priority pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt_s;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// Holds the registered output stage, the pending-write scoreboard and the
// issue-stage hazard check (RAW on rs1/rs2, WAW on rd). No forwarding path:
// a pending bit clears on the same edge that rf commits the data.
module rf_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           wb_valid,
  input  logic [NREQ-1:0][4:0]      wb_rd,
  input  logic [NREQ-1:0][XLEN-1:0] wb_data,
  output logic [NREQ-1:0]           wb_ready,
  output logic                      rf_wr,
  output logic [4:0]                rf_rd,
  output logic [XLEN-1:0]           rf_wrdata,
  input  logic                      iss_valid,
  input  logic [4:0]                iss_rs1,
  input  logic [4:0]                iss_rs2,
  input  logic [4:0]                iss_rd,
  input  logic                      iss_alloc,
  output logic                      iss_stall,
  output logic [31:0]               pending
);

  logic [NREQ-1:0]  gnt_s;
  logic             any_gnt_s;
  reg_idx_t         sel_rd_s;
  logic [XLEN-1:0]  sel_data_s;

  logic             rf_wr_q;
  reg_idx_t         rf_rd_q;
  logic [XLEN-1:0]  rf_wrdata_q;

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic             iss_stall_s;
  logic             set_s;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (wb_valid),
    .gnt_o (gnt_s)
  );

  assign wb_ready = gnt_s;

  // Route the granted requester's rd/data toward the output stage
  always_comb begin
    sel_rd_s   = 5'd0;
    sel_data_s = {XLEN{1'b0}};
    any_gnt_s  = |gnt_s;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s[i]) begin
        sel_rd_s   = wb_rd[i];
        sel_data_s = wb_data[i];
      end else begin
        sel_rd_s   = sel_rd_s;
      end
    end
  end

  // Output stage: one write per granted cycle; x0 writes are suppressed since rf does not hard-wire x0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wr_q     <= 1'b0;
      rf_rd_q     <= 5'd0;
      rf_wrdata_q <= {XLEN{1'b0}};
    end else if (any_gnt_s) begin
      rf_wr_q     <= (sel_rd_s != 5'd0);
      rf_rd_q     <= sel_rd_s;
      rf_wrdata_q <= sel_data_s;
    end else begin
      rf_wr_q     <= 1'b0;
    end
  end

  assign rf_wr     = rf_wr_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wrdata = rf_wrdata_q;

  // Hazard check against in-flight writes; silent during reset
  always_comb begin
    if (rst_n && iss_valid) begin
      iss_stall_s = pending_q[iss_rs1] | pending_q[iss_rs2] |
                    (iss_alloc & pending_q[iss_rd]);
    end else begin
      iss_stall_s = 1'b0;
    end
  end

  assign iss_stall = iss_stall_s;
  assign set_s     = iss_valid & iss_alloc & ~iss_stall_s & (iss_rd != 5'd0);

  // Scoreboard next state: clear on commit, then set on issue so a younger writer wins
  always_comb begin
    pending_d = pending_q;
    if (rf_wr_q) begin
      pending_d = pending_d & ~reg_bit(rf_rd_q);
    end else begin
      pending_d = pending_d;
    end
    if (set_s) begin
      pending_d = pending_d | reg_bit(iss_rd);
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= {NREGS{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule
